pipo_load_arbiter: RTL

PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

---
 rtl/pipo_arb_pkg.sv | 21 ++
 rtl/pipo_reg.sv | 26 ++
 rtl/pipo_load_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared definitions for the PIPO load arbiter: FSM state encoding,
// default sizing constants and the round-robin index helper.
package pipo_arb_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   // Index reached by stepping 'offset' places upward from 'base', wrapping at n.
   function automatic int wrapIndex(input int base, input int offset, input int n);
      int sum;
      sum = base + offset;
      return (sum >= n) ? (sum - n) : sum;
   endfunction

endpackage

// File: rtl/pipo_reg.sv
// Parallel-in parallel-out register shared by all requesters.
// Captures parallel_in on a clock edge where load is high, otherwise holds.
module pipo_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] parallel_out
);

   logic [WIDTH-1:0] r_value;

   // Storage element: clears on reset, loads only when the arbiter strobes load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_value <= '0;
      end else if (load) begin
         r_value <= parallel_in;
      end
   end

   assign parallel_out = r_value;

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared
// PIPO register. Each transaction walks IDLE -> LOAD -> ACK, so a load
// completes every three cycles at best. The search pointer advances past
// the last served requester so continuous requesters rotate strictly.
module pipo_load_arbiter
   import pipo_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       ack,
   output logic [1:0]            grant_id,
   output logic [WIDTH-1:0]      q,
   output logic                  busy,
   output logic [7:0]            load_count
);

   arb_state_t       r_state;
   logic [1:0]       r_ptr;
   logic [1:0]       r_grant;
   logic [WIDTH-1:0] r_data;
   logic [NREQ-1:0]  r_ack;
   logic             r_busy;
   logic [7:0]       r_count;

   logic             w_found;
   logic [1:0]       w_winner;
   logic             w_load;
   logic [1:0]       w_nextPtr;

   // Winner search: first asserted request at or above r_ptr, wrapping to 0.
   always_comb begin
      w_found  = 1'b0;
      w_winner = 2'd0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req[wrapIndex(int'(r_ptr), k, NREQ)]) begin
            w_found  = 1'b1;
            w_winner = 2'(wrapIndex(int'(r_ptr), k, NREQ));
         end
      end
   end

   assign w_nextPtr = (int'(r_grant) == NREQ - 1) ? 2'd0 : (r_grant + 2'd1);
   assign w_load    = (r_state == LOAD);

   // Transaction FSM with registered ack/busy/grant and the saturating load counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ptr   <= 2'd0;
         r_grant <= 2'd0;
         r_data  <= '0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
         r_count <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ack <= '0;
               if (w_found) begin
                  r_grant <= w_winner;
                  r_data  <= req_data[int'(w_winner)*WIDTH +: WIDTH];
                  r_busy  <= 1'b1;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_ack   <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
               r_busy  <= 1'b1;
               r_state <= ACK;
            end
            ACK: begin
               r_ack   <= '0;
               r_busy  <= 1'b0;
               r_ptr   <= w_nextPtr;
               if (r_count != 8'hFF) begin
                  r_count <= r_count + 8'd1;
               end
               r_state <= IDLE;
            end
            default: begin
               r_ack   <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   pipo_reg #(
      .WIDTH (WIDTH)
   ) u_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (w_load),
      .parallel_in  (r_data),
      .parallel_out (q)
   );

   assign ack        = r_ack;
   assign grant_id   = r_grant;
   assign busy       = r_busy;
   assign load_count = r_count;

endmodule
